// File: rtl/wma_filter_mc_if.sv
// Sample-in / result-out handshake bundle for the multi-channel WMA outlier filter.
interface wma_filter_mc_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [CHW-1:0]   in_ch;
  logic [WIDTH-1:0] in_x;
  logic [1:0]       thr_sel;
  logic             out_valid;
  logic             out_ready;
  logic [CHW-1:0]   out_ch;
  logic [WIDTH-1:0] out_wma;
  logic [WIDTH-1:0] out_t1;
  logic [WIDTH-1:0] out_t2;
  logic             out_outlier;
  logic             out_resync;

  modport master (
    output in_valid, in_ch, in_x, thr_sel, out_ready,
    input  in_ready, out_valid, out_ch, out_wma, out_t1, out_t2, out_outlier, out_resync
  );

  modport slave (
    input  in_valid, in_ch, in_x, thr_sel, out_ready,
    output in_ready, out_valid, out_ch, out_wma, out_t1, out_t2, out_outlier, out_resync
  );
endinterface

// File: rtl/wma_filter_mc.sv
// Multi-channel weighted moving average with outlier rejection.
// Each channel keeps wma = (3*wma + x)/4 for samples inside [wma-P, wma+P];
// samples outside are rejected, and REJECT_LIMIT consecutive rejects resync
// the average to the sample. One-cycle latency, single output register.
module wma_filter_mc #(
  parameter int WIDTH        = 8,
  parameter int CHANNELS     = 4,
  parameter int REJECT_LIMIT = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  wma_filter_mc_if.slave  bus
);
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CW  = $clog2(REJECT_LIMIT + 1);
  localparam int EW  = WIDTH + 2;
  localparam logic [CW:0] RL = (CW+1)'(REJECT_LIMIT);

  // per-channel state
  logic [CHANNELS-1:0][WIDTH-1:0] wma_q;
  logic [CHANNELS-1:0]            init_q;
  logic [CHANNELS-1:0][CW-1:0]    cnt_q;

  // output register
  logic             ov_q, outl_q, res_q;
  logic [CHW-1:0]   och_q;
  logic [WIDTH-1:0] owma_q, ot1_q, ot2_q;

  logic             acc, first, in_rng;
  logic [WIDTH-1:0] wma_s, w0, p, t1, t2, w1;
  logic             init_s;
  logic [CW-1:0]    cnt_s, cnt_n;
  logic [CW:0]      cnt_inc;
  logic [WIDTH:0]   sum;
  logic [EW-1:0]    avg_sum;
  logic             outl, res;

  assign bus.in_ready = !ov_q || bus.out_ready;
  assign acc          = bus.in_valid && bus.in_ready;

  // select the addressed channel's state (out-of-range index reads as uninitialised)
  always_comb begin
    wma_s  = '0;
    init_s = 1'b0;
    cnt_s  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (bus.in_ch == CHW'(c)) begin
        wma_s  = wma_q[c];
        init_s = init_q[c];
        cnt_s  = cnt_q[c];
      end
    end
  end

  // threshold offset: base scaled so it keeps the same fraction of full scale
  always_comb begin
    case (bus.thr_sel)
      2'b01:   p = WIDTH'(64  << (WIDTH - 8));
      2'b10:   p = WIDTH'(128 << (WIDTH - 8));
      default: p = WIDTH'(32  << (WIDTH - 8));
    endcase
  end

  // thresholds and average; a clr in the same cycle makes this a first sample
  always_comb begin
    first   = clr || !init_s;
    w0      = first ? bus.in_x : wma_s;
    t1      = (w0 > p) ? w0 - p : '0;
    sum     = {1'b0, w0} + {1'b0, p};
    t2      = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    in_rng  = (bus.in_x >= t1) && (bus.in_x <= t2);
    avg_sum = {2'b00, w0} + {1'b0, w0, 1'b0} + {2'b00, bus.in_x};
    cnt_inc = {1'b0, cnt_s} + 1'b1;
  end

  // accept / reject / resync decision
  always_comb begin
    w1    = w0;
    cnt_n = '0;
    outl  = 1'b0;
    res   = 1'b0;
    if (first) begin
      w1 = bus.in_x;
    end else if (in_rng) begin
      w1 = avg_sum[EW-1:2];
    end else if (cnt_inc < RL) begin
      outl  = 1'b1;
      cnt_n = cnt_inc[CW-1:0];
    end else begin
      w1   = bus.in_x;
      outl = 1'b1;
      res  = 1'b1;
    end
  end

  // channel state: clr wipes flags/counts, the accepted channel is written after it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wma_q  <= '0;
      init_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (clr) begin
        init_q <= '0;
        cnt_q  <= '0;
      end
      if (acc) begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (bus.in_ch == CHW'(c)) begin
            wma_q[c]  <= w1;
            init_q[c] <= 1'b1;
            cnt_q[c]  <= cnt_n;
          end
        end
      end
    end
  end

  // result register: load on accept, drop valid when consumed with nothing new
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q   <= 1'b0;
      och_q  <= '0;
      owma_q <= '0;
      ot1_q  <= '0;
      ot2_q  <= '0;
      outl_q <= 1'b0;
      res_q  <= 1'b0;
    end else if (acc) begin
      ov_q   <= 1'b1;
      och_q  <= bus.in_ch;
      owma_q <= w1;
      ot1_q  <= t1;
      ot2_q  <= t2;
      outl_q <= outl;
      res_q  <= res;
    end else if (bus.out_ready) begin
      ov_q   <= 1'b0;
    end
  end

  assign bus.out_valid   = ov_q;
  assign bus.out_ch      = och_q;
  assign bus.out_wma     = owma_q;
  assign bus.out_t1      = ot1_q;
  assign bus.out_t2      = ot2_q;
  assign bus.out_outlier = outl_q;
  assign bus.out_resync  = res_q;
endmodule

// File: doc/wma_filter_mc.md
WMA_FILTER_MC -- requirements
Module: wma_filter_mc

Interface
REQ-001 Parameter WIDTH, default 8: sample and average width in bits; legal range 8..16.
REQ-002 Parameter CHANNELS, default 4: number of independent sensor channels; legal range 1..16.
REQ-003 Parameter REJECT_LIMIT, default 3: number of consecutive outliers that forces a resync; legal range 1..15.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-006 clr  input  1  synchronous clear of all channel state.
REQ-007 in_valid  input  1  sample offered.
REQ-008 in_ready  output  1  block can accept a sample.
REQ-009 in_ch  input  max(1,clog2(CHANNELS))  channel index of the sample.
REQ-010 in_x  input  WIDTH  sample value, unsigned.
REQ-011 thr_sel  input  2  threshold select: 00=P32, 01=P64, 10=P128, 11=P32.
REQ-012 out_valid  output  1  result held.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out_ch  output  as in_ch  channel of the result.
REQ-015 out_wma  output  WIDTH  updated average (WMA1).
REQ-016 out_t1 / out_t2  output  WIDTH each  lower and upper threshold used for the decision.
REQ-017 out_outlier  output  1  sample rejected; out_resync  output  1  average forced to the sample.

Function
REQ-018 Per channel, the block SHALL hold: wma (WIDTH), init flag (1), and outlier count (clog2(REJECT_LIMIT+1)).
REQ-019 A sample is accepted when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
REQ-020 Latency is 1 cycle: the result is registered on the accepting edge, and out_valid rises in the following cycle.
REQ-021 While out_valid && !out_ready, all out_* SHALL hold stable and in_ready SHALL be 0.
REQ-022 If out_ready=1 and no sample is accepted in a cycle, out_valid SHALL clear at that edge.
REQ-023 Threshold offset P SHALL be the selected base value (32, 64 or 128) shifted left by WIDTH-8.
REQ-024 WMA0 is the stored wma of in_ch, or in_x when that channel's init flag is 0.
REQ-025 T1 = WMA0-P, saturating at 0; T2 = WMA0+P, saturating at 2^WIDTH-1; arithmetic SHALL use WIDTH+2 bits with no wrap.
REQ-026 In-range test (T1 <= in_x <= T2, inclusive) passes: WMA1 = floor((3*WMA0 + in_x)/4), count cleared, out_outlier=0.
REQ-027 Outlier with count+1 < REJECT_LIMIT: WMA1 = WMA0, count incremented, out_outlier=1, out_resync=0.
REQ-028 Outlier with count+1 == REJECT_LIMIT: WMA1 = in_x, count cleared, out_outlier=1, out_resync=1.
REQ-029 First sample on an uninitialised channel: WMA1 = in_x, init flag set, out_outlier=0, out_resync=0.
REQ-030 On accept, the channel state SHALL be written at the same edge, so back-to-back samples on the same channel use the updated value with no stall.
REQ-031 Channels SHALL be fully independent; an accept on one channel SHALL NOT alter another channel's state.
REQ-032 clr=1 SHALL zero all init flags and counts; a sample accepted in the same cycle is processed as a first sample (REQ-029), and its channel ends initialised.
REQ-033 clr SHALL NOT affect a pending out_valid result.

Reset
REQ-034 On rst_n=0: out_valid=0, out_wma/out_t1/out_t2=0, out_ch=0, out_outlier=0, out_resync=0, all wma=0, init flags=0, counts=0.
REQ-035 in_ready SHALL be 1 during and after reset.
REQ-036 Reset asserted mid-transfer SHALL discard the pending result.
REQ-037 Reset deassertion is synchronised externally.

Verification (WIDTH=8, CHANNELS=4, REJECT_LIMIT=3)
REQ-038 After reset, ch0 x=60 sel=00 -> out_wma=60, t1=28, t2=92, outlier=0; then ch0 x=50 -> wma=57, t1=28, t2=92.
REQ-039 ch1 wma=200, sel=10, x=30 three times -> wma 200, 200, 30; t1=72, t2=255; outlier 1,1,1; resync 0,0,1.
REQ-040 ch2 wma=255, sel=00, x=255 -> t1=223, t2=255, wma=255; ch2 wma=10, sel=01, x=0 -> t1=0, t2=74, wma=7.
REQ-041 Boundary: ch3 wma=128, sel=00, x=96 -> in range, wma=120; ch3 wma=128, x=95 -> outlier, wma=128, count=1.
REQ-042 Hold out_ready=0 for 5 cycles with out_valid=1 -> in_ready=0 and outputs stable; release it -> the next sample is accepted in that cycle.
REQ-043 clr and an accept of ch0 x=40 in the same cycle -> out_wma=40; ch1 is then treated as uninitialised on its next sample; rst_n pulsed with out_valid=1 -> out_valid=0 immediately.
